// File: rtl/logic_func_prober.sv
// logic_func_prober: drives a 2-input logical unit through all four {a,b}
// vectors. It samples the unit's output for each vector and rebuilds the
// 4-bit func code from those samples. It then classifies the code and
// compares it with an expected value.
module logic_func_prober #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       probe_a,
  output logic       probe_b,
  input  logic       probe_out,
  input  logic [3:0] func_exp,
  output logic       busy,
  output logic       done,
  output logic [3:0] func_found,
  output logic [1:0] func_class,
  output logic       match
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    PROBE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       shadow_q, shadow_d;
  logic [3:0]       found_q, found_d;
  logic [1:0]       class_q, class_d;
  logic             match_q, match_d;
  logic             done_q, done_d;
  logic [3:0]       shadow_cap;

  function automatic logic [1:0] classify(input logic [3:0] f);
    case (f)
      4'b1000: classify = 2'b01;
      4'b1110: classify = 2'b10;
      4'b0110: classify = 2'b11;
      default: classify = 2'b00;
    endcase
  endfunction

  // State and result registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      found_q  <= '0;
      class_q  <= '0;
      match_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      found_q  <= found_d;
      class_q  <= class_d;
      match_q  <= match_d;
      done_q   <= done_d;
    end
  end

  // Sequencing: hold each vector for SETTLE_CYCLES, then capture and advance
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    found_d    = found_q;
    class_d    = class_q;
    match_d    = match_q;
    done_d     = 1'b0;
    shadow_cap = shadow_q;
    shadow_cap[idx_q] = probe_out;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = PROBE;
          idx_d    = '0;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      PROBE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          shadow_d = shadow_cap;
          if (idx_q == 2'd3) begin
            // The last sample goes straight into the result, bypassing shadow
            found_d = shadow_cap;
            class_d = classify(shadow_cap);
            match_d = (shadow_cap == func_exp);
            done_d  = 1'b1;
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: probe vector driven only while a sequence runs
  always_comb begin
    busy       = (state_q == PROBE);
    probe_a    = busy & idx_q[1];
    probe_b    = busy & idx_q[0];
    done       = done_q;
    func_found = found_q;
    func_class = class_q;
    match      = match_q;
  end

endmodule

// File: tb/tb_logic_func_prober.sv
// Directed bench for logic_func_prober at settle lengths 1, 2 and 3.
module tb_logic_func_prober;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic       start1 = 1'b0, start2 = 1'b0, start3 = 1'b0;
  logic [3:0] func1 = '0, func2 = '0, func3 = '0;
  logic [3:0] fexp1 = '0, fexp2 = '0, fexp3 = '0;
  logic       pa1, pb1, po1, busy1, done1, m1;
  logic       pa2, pb2, po2, busy2, done2, m2;
  logic       pa3, pb3, po3, busy3, done3, m3;
  logic [3:0] ff1, ff2, ff3;
  logic [1:0] fc1, fc2, fc3;

  // Behavioural logical units under probe: out = func[{a,b}]
  assign po1 = func1[{pa1, pb1}];
  assign po2 = func2[{pa2, pb2}];
  assign po3 = func3[{pa3, pb3}];

  logic_func_prober #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .probe_a(pa1), .probe_b(pb1),
    .probe_out(po1), .func_exp(fexp1), .busy(busy1), .done(done1),
    .func_found(ff1), .func_class(fc1), .match(m1));

  logic_func_prober #(.SETTLE_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .probe_a(pa2), .probe_b(pb2),
    .probe_out(po2), .func_exp(fexp2), .busy(busy2), .done(done2),
    .func_found(ff2), .func_class(fc2), .match(m2));

  logic_func_prober #(.SETTLE_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .probe_a(pa3), .probe_b(pb3),
    .probe_out(po3), .func_exp(fexp3), .busy(busy3), .done(done3),
    .func_found(ff3), .func_class(fc3), .match(m3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int ndone;
    int dpos[4];
    logic [1:0] p2, p3;
    logic ff_bad;

    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_probe", 32'({pa1, pb1}), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_found", 32'(ff1), 32'd0);
    chk("rst_class", 32'(fc1), 32'd0);
    chk("rst_match", 32'(m1), 32'd0);
    rst = 1'b0;
    tick();

    // 1: S=1, OR unit, probe vectors one cycle each
    func1 = 4'b1110; fexp1 = 4'b1110; start1 = 1'b1;
    tick(); start1 = 1'b0;
    chk("t1_busy", 32'(busy1), 32'd1);
    chk("t1_vec0", 32'({pa1, pb1}), 32'd0);
    tick(); chk("t1_vec1", 32'({pa1, pb1}), 32'd1);
    tick(); chk("t1_vec2", 32'({pa1, pb1}), 32'd2);
    tick(); chk("t1_vec3", 32'({pa1, pb1}), 32'd3);
    chk("t1_nodone_early", 32'(done1), 32'd0);
    tick();
    chk("t1_done", 32'(done1), 32'd1);
    chk("t1_busy_end", 32'(busy1), 32'd0);
    chk("t1_probe_end", 32'({pa1, pb1}), 32'd0);
    chk("t1_found", 32'(ff1), 32'b1110);
    chk("t1_class", 32'(fc1), 32'b10);
    chk("t1_match", 32'(m1), 32'd1);
    tick();
    chk("t1_done_drop", 32'(done1), 32'd0);
    chk("t1_found_hold", 32'(ff1), 32'b1110);

    // 2: S=3, XOR unit, 12-cycle latency
    func3 = 4'b0110; fexp3 = 4'b0110; start3 = 1'b1;
    tick(); start3 = 1'b0;
    n = 0; p2 = 2'bxx; p3 = 2'bxx;
    while (!done3 && n < 40) begin
      tick(); n++;
      if (n == 2) p2 = {pa3, pb3};
      if (n == 3) p3 = {pa3, pb3};
    end
    chk("t2_latency", 32'(n), 32'd12);
    chk("t2_hold_vec0", 32'(p2), 32'd0);
    chk("t2_vec1", 32'(p3), 32'd1);
    chk("t2_found", 32'(ff3), 32'b0110);
    chk("t2_class", 32'(fc3), 32'b11);
    chk("t2_match", 32'(m3), 32'd1);

    // 3: S=1, AND unit, expectation differs
    func1 = 4'b1000; fexp1 = 4'b1110; start1 = 1'b1;
    tick(); start1 = 1'b0;
    n = 0;
    while (!done1 && n < 40) begin tick(); n++; end
    chk("t3_latency", 32'(n), 32'd4);
    chk("t3_found", 32'(ff1), 32'b1000);
    chk("t3_class", 32'(fc1), 32'b01);
    chk("t3_match", 32'(m1), 32'd0);
    tick();

    // 4: S=1, start re-asserted while busy is ignored
    func1 = 4'b0001; fexp1 = 4'b0001; start1 = 1'b1;
    tick();
    n = 0; ndone = 0; dpos[0] = -1;
    while (n < 14) begin
      tick(); n++;
      if (n == 3) start1 = 1'b0;
      if (done1) begin
        if (ndone == 0) dpos[0] = n;
        ndone++;
      end
    end
    chk("t4_one_done", 32'(ndone), 32'd1);
    chk("t4_done_pos", 32'(dpos[0]), 32'd4);
    chk("t4_found", 32'(ff1), 32'b0001);
    chk("t4_class", 32'(fc1), 32'b00);

    // 5: S=2, first a full run to leave a non-zero result
    func2 = 4'b0110; fexp2 = 4'b0110; start2 = 1'b1;
    tick(); start2 = 1'b0;
    n = 0;
    while (!done2 && n < 40) begin tick(); n++; end
    chk("t5_pre_latency", 32'(n), 32'd8);
    chk("t5_pre_found", 32'(ff2), 32'b0110);
    tick();
    // Mid-sequence reset, five cycles in
    func2 = 4'b1110; start2 = 1'b1;
    tick(); start2 = 1'b0;
    repeat (5) tick();
    chk("t5_mid_vec", 32'({pa2, pb2}), 32'd2);
    chk("t5_mid_busy", 32'(busy2), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(busy2), 32'd0);
    chk("t5_rst_probe", 32'({pa2, pb2}), 32'd0);
    chk("t5_rst_found", 32'(ff2), 32'd0);
    chk("t5_rst_class", 32'(fc2), 32'd0);
    chk("t5_rst_match", 32'(m2), 32'd0);
    #1 rst = 1'b0;
    ndone = 0;
    repeat (6) begin tick(); if (done2) ndone++; end
    chk("t5_no_done", 32'(ndone), 32'd0);
    // Fresh start completes normally
    func2 = 4'b1000; fexp2 = 4'b1000; start2 = 1'b1;
    tick(); start2 = 1'b0;
    n = 0;
    while (!done2 && n < 40) begin tick(); n++; end
    chk("t5_latency", 32'(n), 32'd8);
    chk("t5_found", 32'(ff2), 32'b1000);
    chk("t5_class", 32'(fc2), 32'b01);
    chk("t5_match", 32'(m2), 32'd1);
    tick();

    // 6: S=1, start held high gives back-to-back runs
    func1 = 4'b0110; fexp1 = 4'b0110; start1 = 1'b1;
    tick();
    ndone = 0; ff_bad = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done1) begin
        if (ndone < 4) dpos[ndone] = k;
        ndone++;
      end
      if (k >= 4 && ff1 !== 4'b0110) ff_bad = 1'b1;
    end
    chk("t6_done_count", 32'(ndone), 32'd4);
    chk("t6_done0", 32'(dpos[0]), 32'd4);
    chk("t6_done1", 32'(dpos[1]), 32'd9);
    chk("t6_done2", 32'(dpos[2]), 32'd14);
    chk("t6_done3", 32'(dpos[3]), 32'd19);
    chk("t6_found_stable", 32'(ff_bad), 32'd0);
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 20) begin tick(); n++; end
    chk("t6_drain", 32'(done1), 32'd1);
    tick();
    chk("t6_idle", 32'(busy1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
